// File: rtl/dbns_conv_sched.sv
// Two-requester scheduler converting 5-bit operands into greedy
// double-base (2^i * 3^j) term bitmaps, one term per cycle.
module dbns_conv_sched #(
    parameter int NUM_BITS = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [NUM_BITS-1:0] req_op0,
    input  logic [NUM_BITS-1:0] req_op1,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_id,
    output logic [11:0]         res_map,
    output logic [2:0]          res_terms,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] resid_q, resid_d;
    logic [11:0]         map_q, map_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                id_q, id_d;
    logic                rr_q, rr_d;
    logic                res_id_q, res_id_d;
    logic [11:0]         res_map_q, res_map_d;
    logic [2:0]          res_terms_q, res_terms_d;

    logic [1:0]          grant;
    logic                gnt_id;
    logic [NUM_BITS-1:0] pick_val;
    logic [11:0]         pick_bit;

    // Round-robin grant in IDLE; gated by reset_n so ready stays low while held in reset.
    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (state_q == IDLE && reset_n) begin
            unique case (req_valid)
                2'b01:   gnt_id = 1'b0;
                2'b10:   gnt_id = 1'b1;
                2'b11:   gnt_id = rr_q;
                default: gnt_id = 1'b0;
            endcase
            if (|req_valid) begin
                grant = gnt_id ? 2'b10 : 2'b01;
            end
        end
    end

    // Largest term not exceeding the residue, with its bitmap position 4*j+i.
    always_comb begin
        pick_val = '0;
        pick_bit = '0;
        if (resid_q >= NUM_BITS'(24)) begin
            pick_val = NUM_BITS'(24);
            pick_bit = 12'h080;
        end else if (resid_q >= NUM_BITS'(18)) begin
            pick_val = NUM_BITS'(18);
            pick_bit = 12'h200;
        end else if (resid_q >= NUM_BITS'(12)) begin
            pick_val = NUM_BITS'(12);
            pick_bit = 12'h040;
        end else if (resid_q >= NUM_BITS'(9)) begin
            pick_val = NUM_BITS'(9);
            pick_bit = 12'h100;
        end else if (resid_q >= NUM_BITS'(8)) begin
            pick_val = NUM_BITS'(8);
            pick_bit = 12'h008;
        end else if (resid_q >= NUM_BITS'(6)) begin
            pick_val = NUM_BITS'(6);
            pick_bit = 12'h020;
        end else if (resid_q >= NUM_BITS'(4)) begin
            pick_val = NUM_BITS'(4);
            pick_bit = 12'h004;
        end else if (resid_q >= NUM_BITS'(3)) begin
            pick_val = NUM_BITS'(3);
            pick_bit = 12'h010;
        end else if (resid_q >= NUM_BITS'(2)) begin
            pick_val = NUM_BITS'(2);
            pick_bit = 12'h002;
        end else if (resid_q >= NUM_BITS'(1)) begin
            pick_val = NUM_BITS'(1);
            pick_bit = 12'h001;
        end
    end

    // Next-state logic: grant, one greedy term per CONV cycle, hold result in DONE.
    always_comb begin
        state_d     = state_q;
        resid_d     = resid_q;
        map_d       = map_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        rr_d        = rr_q;
        res_id_d    = res_id_q;
        res_map_d   = res_map_q;
        res_terms_d = res_terms_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d = CONV;
                    resid_d = gnt_id ? req_op1 : req_op0;
                    map_d   = '0;
                    cnt_d   = '0;
                    id_d    = gnt_id;
                    rr_d    = ~gnt_id;
                end
            end
            CONV: begin
                if (resid_q != '0) begin
                    resid_d = resid_q - pick_val;
                    map_d   = map_q | pick_bit;
                    cnt_d   = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
                end
                // Finish as soon as the last term is taken, so the
                // result is published on the following cycle.
                if (resid_d == '0) begin
                    state_d     = DONE;
                    res_id_d    = id_q;
                    res_map_d   = map_d;
                    res_terms_d = cnt_d;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            resid_q     <= '0;
            map_q       <= '0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            rr_q        <= 1'b0;
            res_id_q    <= 1'b0;
            res_map_q   <= '0;
            res_terms_q <= '0;
        end else begin
            state_q     <= state_d;
            resid_q     <= resid_d;
            map_q       <= map_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            res_id_q    <= res_id_d;
            res_map_q   <= res_map_d;
            res_terms_q <= res_terms_d;
        end
    end

    assign req_ready = grant;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_id    = res_id_q;
    assign res_map   = res_map_q;
    assign res_terms = res_terms_q;

endmodule

// File: tb/tb_dbns_conv_sched.sv
// Bench for dbns_conv_sched: directed scenarios plus exhaustive and
// random operands checked against a greedy double-base reference model.
module tb_dbns_conv_sched;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req_op0;
    logic [4:0]  req_op1;
    logic        res_valid;
    logic        res_ready;
    logic        res_id;
    logic [11:0] res_map;
    logic [2:0]  res_terms;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic        tb_ptr;
    logic        last_id;
    logic [11:0] last_map;
    logic [2:0]  last_terms;

    always #5 clock = ~clock;

    dbns_conv_sched #(.NUM_BITS(5)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_map   (res_map),
        .res_terms (res_terms),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int term_val(input int i, input int j);
        int v;
        v = 1 << i;
        for (int k = 0; k < j; k++) v = v * 3;
        return v;
    endfunction

    // Greedy decomposition straight from the term set definition.
    function automatic void model(input int op, output logic [11:0] m,
                                  output int n);
        int r;
        int best;
        int bix;
        int v;
        r = op;
        m = '0;
        n = 0;
        while (r > 0) begin
            best = 0;
            bix  = 0;
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 4; i++) begin
                    v = term_val(i, j);
                    if (v <= 31 && v <= r && v > best) begin
                        best = v;
                        bix  = 4 * j + i;
                    end
                end
            end
            r      = r - best;
            m[bix] = 1'b1;
            n++;
        end
    endfunction

    function automatic int sum_map(input logic [11:0] m);
        int s;
        s = 0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (m[4 * j + i]) s = s + term_val(i, j);
            end
        end
        return s;
    endfunction

    task automatic wait_grant(input logic [1:0] exp, output int n);
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("grant", req_ready, exp);
        tb_ptr = exp[0];
        @(posedge clock);
        #1;
    endtask

    task automatic finish_result(input int id, input int op, input int bp);
        logic [11:0] em;
        int          en;
        int          elat;
        int          lat;
        model(op, em, en);
        elat = (en == 0) ? 2 : en + 1;
        lat  = 0;
        do begin
            @(negedge clock);
            lat++;
            if (res_valid !== 1'b1) begin
                check("conv_busy", busy, 1);
                check("conv_hold_map", res_map, last_map);
                check("conv_hold_terms", res_terms, last_terms);
                check("conv_hold_id", res_id, last_id);
                check("conv_ready", req_ready, 0);
            end
        end while (res_valid !== 1'b1 && lat < 30);
        check("latency", lat, elat);
        check("res_id", res_id, id);
        check("res_map", res_map, em);
        check("res_terms", res_terms, en);
        check("map_sum", sum_map(res_map), op);
        check("popcount", $countones(res_map), res_terms);
        check("done_ready", req_ready, 0);
        check("done_busy", busy, 1);
        repeat (bp) begin
            @(negedge clock);
            check("bp_valid", res_valid, 1);
            check("bp_map", res_map, em);
            check("bp_terms", res_terms, en);
            check("bp_id", res_id, id);
            check("bp_ready", req_ready, 0);
        end
        if (bp > 0) res_ready = 1'b1;
        @(negedge clock);
        check("idle_valid", res_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_map", res_map, em);
        check("idle_terms", res_terms, en);
        last_id    = id[0];
        last_map   = em;
        last_terms = en[2:0];
    endtask

    initial begin
        int          n;
        int          bp;
        int          id;
        int          op;
        logic [1:0]  exp_g;

        reset_n    = 1'b0;
        req_valid  = 2'b00;
        req_op0    = '0;
        req_op1    = '0;
        res_ready  = 1'b1;
        tb_ptr     = 1'b0;
        last_id    = 1'b0;
        last_map   = '0;
        last_terms = '0;

        @(negedge clock);
        check("rst_ready", req_ready, 0);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_id", res_id, 0);
        check("rst_map", res_map, 0);
        check("rst_terms", res_terms, 0);
        reset_n = 1'b1;

        // Single request, operand 31 on requester 0.
        req_op0   = 5'd31;
        req_valid = 2'b01;
        wait_grant(2'b01, n);
        req_valid = 2'b00;
        req_op0   = 5'($urandom);
        finish_result(0, 31, 0);

        // Zero operand on requester 1.
        req_op1   = 5'd0;
        req_valid = 2'b10;
        wait_grant(2'b10, n);
        req_valid = 2'b00;
        req_op1   = 5'($urandom);
        finish_result(1, 0, 0);

        // Contention: both held valid, grants must alternate.
        req_op0   = 5'd17;
        req_op1   = 5'd5;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            exp_g = tb_ptr ? 2'b10 : 2'b01;
            wait_grant(exp_g, n);
            if (k > 0) check("rr_immediate", n, 0);
            id = exp_g[1] ? 1 : 0;
            finish_result(id, (id == 1) ? 5 : 17, 0);
        end
        req_valid = 2'b00;

        // Backpressure with a pending request from the other side.
        res_ready = 1'b0;
        req_op0   = 5'd13;
        req_valid = 2'b01;
        wait_grant(2'b01, n);
        req_op0   = 5'($urandom);
        req_op1   = 5'd9;
        req_valid = 2'b10;
        finish_result(0, 13, 10);
        wait_grant(2'b10, n);
        check("bp_next_grant", n, 0);
        req_valid = 2'b00;
        finish_result(1, 9, 0);

        // Reset in the middle of converting 23.
        res_ready = 1'b1;
        req_op0   = 5'd23;
        req_valid = 2'b01;
        wait_grant(2'b01, n);
        req_valid = 2'b00;
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        #1;
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_id", res_id, 0);
        check("mid_rst_map", res_map, 0);
        check("mid_rst_terms", res_terms, 0);
        tb_ptr     = 1'b0;
        last_id    = 1'b0;
        last_map   = '0;
        last_terms = '0;
        @(negedge clock);
        check("held_rst_ready", req_ready, 0);
        check("held_rst_busy", busy, 0);
        req_valid = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("post_rst_valid", res_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        req_op0   = 5'd5;
        req_op1   = 5'd3;
        req_valid = 2'b11;
        wait_grant(2'b01, n);
        req_valid = 2'b10;
        finish_result(0, 5, 0);
        wait_grant(2'b10, n);
        req_valid = 2'b00;
        finish_result(1, 3, 0);

        // Every operand on each requester, random backpressure.
        for (int o = 0; o < 32; o++) begin
            for (int r = 0; r < 2; r++) begin
                bp        = int'($urandom_range(0, 2));
                res_ready = (bp == 0);
                req_op0   = (r == 0) ? 5'(o) : 5'($urandom);
                req_op1   = (r == 1) ? 5'(o) : 5'($urandom);
                req_valid = (r == 1) ? 2'b10 : 2'b01;
                wait_grant(req_valid, n);
                req_valid = 2'b00;
                req_op0   = 5'($urandom);
                req_op1   = 5'($urandom);
                finish_result(r, o, bp);
            end
        end

        // Random requester and operand.
        for (int k = 0; k < 16; k++) begin
            id        = int'($urandom_range(0, 1));
            op        = int'($urandom_range(0, 31));
            bp        = int'($urandom_range(0, 3));
            res_ready = (bp == 0);
            req_op0   = (id == 0) ? 5'(op) : 5'($urandom);
            req_op1   = (id == 1) ? 5'(op) : 5'($urandom);
            req_valid = (id == 1) ? 2'b10 : 2'b01;
            wait_grant(req_valid, n);
            req_valid = 2'b00;
            req_op0   = 5'($urandom);
            req_op1   = 5'($urandom);
            finish_result(id, op, bp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
